// File: rtl/sram_responder.sv
// Bus-to-async-SRAM responder: captures one bus request, runs a SETUP/ACCESS
// strobe sequence of WAIT_CYCLES+1 access cycles, then pulses ack for one cycle.
module sram_responder #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_addr,
  input  logic [7:0]  i_dat,
  output logic [7:0]  o_dat,
  input  logic        i_cs,
  input  logic        i_we,
  output logic        o_ack,
  output logic [15:0] o_sram_addr,
  output logic [7:0]  o_sram_dat,
  input  logic [7:0]  i_sram_dat,
  output logic        o_sram_ce_n,
  output logic        o_sram_oe_n,
  output logic        o_sram_we_n
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ACK} state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic        we_q, we_next;
  logic [15:0] addr_next;
  logic [7:0]  wdat_next, rdat_next;
  logic        ce_n_next, oe_n_next, we_n_next, ack_next;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    we_next    = we_q;
    addr_next  = o_sram_addr;
    wdat_next  = o_sram_dat;
    rdat_next  = o_dat;
    case (state)
      IDLE: begin
        if (i_cs) begin
          state_next = SETUP;
          we_next    = i_we;
          addr_next  = i_addr;
          wdat_next  = i_dat;
        end
      end
      SETUP: begin
        state_next = ACCESS;
        cnt_next   = WAIT_LOAD;
      end
      ACCESS: begin
        if (cnt == 4'd0) begin
          state_next = ACK;
          if (!we_q) rdat_next = i_sram_dat;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      ACK: state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Strobes are registered from the next state so they line up with it;
    // we_n only falls in ACCESS, so it rises one cycle before the bus is released.
    ce_n_next = !(state_next == SETUP || state_next == ACCESS);
    oe_n_next = !((state_next == SETUP || state_next == ACCESS) && !we_next);
    we_n_next = !(state_next == ACCESS && we_next);
    ack_next  = (state_next == ACK);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      we_q        <= 1'b0;
      o_sram_addr <= 16'h0000;
      o_sram_dat  <= 8'h00;
      o_dat       <= 8'h00;
      o_sram_ce_n <= 1'b1;
      o_sram_oe_n <= 1'b1;
      o_sram_we_n <= 1'b1;
      o_ack       <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      we_q        <= we_next;
      o_sram_addr <= addr_next;
      o_sram_dat  <= wdat_next;
      o_dat       <= rdat_next;
      o_sram_ce_n <= ce_n_next;
      o_sram_oe_n <= oe_n_next;
      o_sram_we_n <= we_n_next;
      o_ack       <= ack_next;
    end
  end

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: three instances (WAIT_CYCLES 1, 0, 15)
// each attached to a simple asynchronous SRAM model.
module tb_sram_responder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // WAIT_CYCLES = 1 instance
  logic [15:0] addr1, sa1;
  logic [7:0]  dat1, rdat1, sd1, srd1;
  logic        cs1, we1, ack1, ce1, oe1, wen1;
  logic [7:0]  mem1 [0:65535];

  sram_responder #(.WAIT_CYCLES(1)) dut1 (
    .i_clk(clk), .i_reset(rst_n), .i_addr(addr1), .i_dat(dat1), .o_dat(rdat1),
    .i_cs(cs1), .i_we(we1), .o_ack(ack1), .o_sram_addr(sa1), .o_sram_dat(sd1),
    .i_sram_dat(srd1), .o_sram_ce_n(ce1), .o_sram_oe_n(oe1), .o_sram_we_n(wen1)
  );

  always @(posedge clk) if (!ce1 && !wen1) mem1[sa1] <= sd1;
  assign srd1 = mem1[sa1];

  // WAIT_CYCLES = 0 and 15 instances; their SRAM returns addr_hi ^ addr_lo
  logic [15:0] addr0, sa0, addr15, sa15;
  logic [7:0]  rdat0, sd0, rdat15, sd15;
  logic        cs0, ack0, ce0, oe0, wen0;
  logic        cs15, ack15, ce15, oe15, wen15;

  sram_responder #(.WAIT_CYCLES(0)) dut0 (
    .i_clk(clk), .i_reset(rst_n), .i_addr(addr0), .i_dat(8'h00), .o_dat(rdat0),
    .i_cs(cs0), .i_we(1'b0), .o_ack(ack0), .o_sram_addr(sa0), .o_sram_dat(sd0),
    .i_sram_dat(sa0[15:8] ^ sa0[7:0]), .o_sram_ce_n(ce0), .o_sram_oe_n(oe0),
    .o_sram_we_n(wen0)
  );

  sram_responder #(.WAIT_CYCLES(15)) dut15 (
    .i_clk(clk), .i_reset(rst_n), .i_addr(addr15), .i_dat(8'h00), .o_dat(rdat15),
    .i_cs(cs15), .i_we(1'b0), .o_ack(ack15), .o_sram_addr(sa15), .o_sram_dat(sd15),
    .i_sram_dat(sa15[15:8] ^ sa15[7:0]), .o_sram_ce_n(ce15), .o_sram_oe_n(oe15),
    .o_sram_we_n(wen15)
  );

  logic [7:0] exp_q[$];
  logic [7:0] ref_mem [0:7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One pulsed request on dut1, observed for 10 cycles after the request cycle.
  task automatic run_txn(input logic we, input logic [15:0] a, input logic [7:0] d,
                         output int acks, output int ack_at, output int ce_lo,
                         output int oe_lo, output int we_lo, output int bad_bus,
                         output int overlap, output logic [7:0] rd);
    acks = 0; ack_at = -1; ce_lo = 0; oe_lo = 0; we_lo = 0;
    bad_bus = 0; overlap = 0; rd = 8'hxx;
    cs1 = 1'b1; we1 = we; addr1 = a; dat1 = d;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 1) begin
        cs1 = 1'b0; addr1 = 16'($urandom); dat1 = 8'($urandom); we1 = 1'($urandom);
      end
      if (!ce1) ce_lo++;
      if (!oe1) oe_lo++;
      if (!wen1) we_lo++;
      if (!oe1 && !wen1) overlap++;
      if ((!ce1 || !wen1 || (ack1 && we)) && (sa1 !== a || (we && sd1 !== d))) bad_bus++;
      if (ack1) begin
        acks++; ack_at = c; rd = rdat1;
      end
    end
  endtask

  int acks, ack_at, ce_lo, oe_lo, we_lo, bad_bus, overlap;
  int tot_overlap, tot_bad;
  logic [7:0] rd;
  int q0[$];
  int q15[$];
  logic [7:0] rd0_first, rd15_first;

  initial begin
    for (int i = 0; i < 65536; i++) mem1[i] = 8'h00;
    for (int i = 0; i < 8; i++) ref_mem[i] = 8'h00;
    rst_n = 1'b0;
    cs1 = 1'b1; we1 = 1'b0; addr1 = 16'h1234; dat1 = 8'h11;
    cs0 = 1'b0; addr0 = 16'h1234; cs15 = 1'b0; addr15 = 16'hABCD;

    // Reset with cs held high: nothing may start
    repeat (3) step();
    chk("rst_ack", ack1, 0);
    chk("rst_ce_n", ce1, 1);
    chk("rst_oe_n", oe1, 1);
    chk("rst_we_n", wen1, 1);
    chk("rst_addr", sa1, 16'h0000);
    chk("rst_sdat", sd1, 8'h00);
    chk("rst_odat", rdat1, 8'h00);
    chk("rst_ce_n_w15", ce15, 1);
    cs1 = 1'b0;
    rst_n = 1'b1;
    step();

    // Write A5 to 1234
    run_txn(1'b1, 16'h1234, 8'hA5, acks, ack_at, ce_lo, oe_lo, we_lo, bad_bus, overlap, rd);
    chk("wr_we_low_cycles", we_lo, 2);
    chk("wr_oe_low_cycles", oe_lo, 0);
    chk("wr_ce_low_cycles", ce_lo, 3);
    chk("wr_ack_cycle", ack_at, 4);
    chk("wr_ack_count", acks, 1);
    chk("wr_bus_stable", bad_bus, 0);
    chk("wr_sram_content", mem1[16'h1234], 8'hA5);

    // Read 5A from 1234
    mem1[16'h1234] = 8'h5A;
    run_txn(1'b0, 16'h1234, 8'h00, acks, ack_at, ce_lo, oe_lo, we_lo, bad_bus, overlap, rd);
    chk("rd_oe_low_cycles", oe_lo, 3);
    chk("rd_we_low_cycles", we_lo, 0);
    chk("rd_ack_cycle", ack_at, 4);
    chk("rd_data_at_ack", rd, 8'h5A);
    chk("rd_addr_stable", bad_bus, 0);

    // One-cycle cs pulse, write 3C to FFFF: exactly one transaction
    run_txn(1'b1, 16'hFFFF, 8'h3C, acks, ack_at, ce_lo, oe_lo, we_lo, bad_bus, overlap, rd);
    chk("pulse_ack_count", acks, 1);
    chk("pulse_ce_low_cycles", ce_lo, 3);
    chk("pulse_sram_content", mem1[16'hFFFF], 8'h3C);
    chk("pulse_bus_stable", bad_bus, 0);
    chk("odat_kept_after_write", rdat1, 8'h5A);

    // Reset during ACCESS of a write
    cs1 = 1'b1; we1 = 1'b1; addr1 = 16'h2000; dat1 = 8'h77;
    step();
    cs1 = 1'b0;
    step();
    chk("abort_in_access", wen1, 0);
    rst_n = 1'b0;
    step();
    chk("abort_ce_n", ce1, 1);
    chk("abort_oe_n", oe1, 1);
    chk("abort_we_n", wen1, 1);
    chk("abort_ack", ack1, 0);
    chk("abort_odat", rdat1, 8'h00);
    rst_n = 1'b1;
    acks = 0; ce_lo = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (ack1) acks++;
      if (!ce1) ce_lo++;
    end
    chk("abort_no_ack", acks, 0);
    chk("abort_no_restart", ce_lo, 0);

    // Back-to-back reads with cs held high on the W=0 and W=15 instances
    cs0 = 1'b1; cs15 = 1'b1;
    rd0_first = 8'h00; rd15_first = 8'h00;
    for (int c = 1; c <= 60; c++) begin
      step();
      if (ack0) begin
        if (q0.size() == 0) rd0_first = rdat0;
        q0.push_back(c);
      end
      if (ack15) begin
        if (q15.size() == 0) rd15_first = rdat15;
        q15.push_back(c);
      end
    end
    cs0 = 1'b0; cs15 = 1'b0;
    chk("w0_ack_count", q0.size(), 15);
    chk("w0_first_ack", q0.size() > 0 ? q0[0] : -1, 3);
    chk("w0_period_a", q0.size() > 2 ? q0[1] - q0[0] : -1, 4);
    chk("w0_period_b", q0.size() > 2 ? q0[2] - q0[1] : -1, 4);
    chk("w0_rdata", rd0_first, 8'h26);
    chk("w15_ack_count", q15.size(), 3);
    chk("w15_first_ack", q15.size() > 0 ? q15[0] : -1, 18);
    chk("w15_period_a", q15.size() > 2 ? q15[1] - q15[0] : -1, 19);
    chk("w15_period_b", q15.size() > 2 ? q15[2] - q15[1] : -1, 19);
    chk("w15_rdata", rd15_first, 8'h66);
    step();

    // Random read/write mix over a small address window
    tot_overlap = 0; tot_bad = 0;
    for (int t = 0; t < 24; t++) begin
      logic        rwe;
      logic [2:0]  ri;
      logic [7:0]  rdv;
      rwe = 1'($urandom_range(0, 1));
      ri  = 3'($urandom_range(0, 7));
      rdv = 8'($urandom_range(0, 255));
      if (rwe) ref_mem[ri] = rdv;
      else exp_q.push_back(ref_mem[ri]);
      run_txn(rwe, {13'h0078, ri}, rdv, acks, ack_at, ce_lo, oe_lo, we_lo, bad_bus, overlap, rd);
      tot_overlap += overlap;
      tot_bad += bad_bus;
      chk("rand_ack_count", acks, 1);
      if (!rwe && exp_q.size() > 0) chk("rand_read_data", rd, exp_q.pop_front());
    end
    chk("rand_oe_we_overlap", tot_overlap, 0);
    chk("rand_bus_stable", tot_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
